prog_field_editor: RTL
======================

Name: prog_field_editor

Overview:
- Consumer of the one-hot programming-mode code (001 = date, 010 = time, 100 = timer) produced by the switch decoder.
- On mode entry, snapshots the live RTC values for the selected group into edit registers.
- Lets the user move a cursor across three fields and increment or decrement them with wrap-around limits.
- On mode exit, issues a single-cycle commit strobe so the RTC write path can store the edited group.

Parameters:
- FW, 7, width of each field value (binary, unsigned).
- YEAR_MAX, 99, upper limit of the year field.
- DAY_MAX, 31, upper limit of the day field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- prog  in  3  one-hot mode code: 001 date, 010 time, 100 timer, 000 none
- btn_up  in  1  single-cycle pulse (already debounced): increment the field under the cursor
- btn_down  in  1  single-cycle pulse: decrement the field under the cursor
- btn_right  in  1  single-cycle pulse: cursor +1
- btn_left  in  1  single-cycle pulse: cursor -1
- live_f0 / live_f1 / live_f2  in  FW each  current RTC values for the group selected by prog
- mode  out  2  00 idle, 01 date, 10 time, 11 timer (reflects the latched group)
- cursor  out  2  active field index, 0..2
- f0 / f1 / f2  out  FW each  edit registers
- wr_stb  out  1  one-cycle commit strobe
- wr_grp  out  2  group being committed (same encoding as mode); valid while wr_stb is high

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE; mode 00, cursor 0, f0/f1/f2 0, wr_stb 0, wr_grp 00.
- Reset mid-edit: discards the edit and produces no commit.
- Group decode:
  - Only 001, 010 and 100 are valid groups.
  - 000, and any non-one-hot code, is treated as "none".
- FSM states: IDLE, LOAD, EDIT, COMMIT.
- IDLE:
  - mode = 00.
  - f0..f2 hold their last values.
  - Buttons are ignored.
  - Valid prog -> latch group into mode, go to LOAD.
- LOAD (exactly 1 cycle):
  - f0..f2 <= live_f0..live_f2; cursor <= 0.
  - Go to EDIT. Buttons are ignored.
- EDIT:
  - If the decoded prog differs from the latched mode (including "none"), go to COMMIT. Buttons are ignored in that cycle.
  - Otherwise, apply at most one action per cycle, with priority up > down > right > left.
- Field limits (min..max):
  - Date: f0 day 1..DAY_MAX, f1 month 1..12, f2 year 0..YEAR_MAX.
  - Time and timer: f0 hour 0..23, f1 minute 0..59, f2 second 0..59.
- Up/down arithmetic:
  - Up: if value >= max, go to min; otherwise +1.
  - Down: if value <= min, go to max; otherwise -1.
  - This also clamps out-of-range loaded values on the first press.
  - No day/month cross-check.
- Cursor: right wraps 2->0; left wraps 0->2.
- COMMIT (exactly 1 cycle):
  - wr_stb = 1, wr_grp = mode; f0..f2 stable.
  - Next state IDLE, with mode cleared to 00 on that same edge.
  - If prog then shows another valid group, IDLE -> LOAD proceeds normally.
  - Direct group-to-group change: old group commits, then new group loads. Minimum 3 cycles from change to EDIT.
- Latency:
  - prog change sampled at edge n -> wr_stb high for the cycle after edge n.
  - Valid prog sampled in IDLE at edge n -> f0..f2 loaded at edge n+1; buttons accepted from edge n+2.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then prog=010 with live=(13,45,07): at edge+2, mode=10, cursor=0, f=(13,45,07), wr_stb=0.
- Time group, f0=23: btn_up -> f0=0. Then btn_down -> f0=23. Cursor to 1 via btn_right, f1=0, btn_down -> f1=59.
- Date group, live=(0,13,99): btn_up on f0 -> 1. Cursor 1, btn_up -> 1 (13 >= 12 wraps). Cursor 2, btn_up -> 0.
- Cursor wrap and priority: btn_left at cursor 0 -> 2. btn_up and btn_right together -> only the field increments, cursor unchanged.
- Exit commit: edit timer to (0,5,30), then prog=000 -> exactly one wr_stb cycle with wr_grp=11, f=(0,5,30); then mode=00. prog=011 behaves the same as 000.
- Reset asserted in EDIT with prog still 001: no wr_stb, all outputs return to reset values. After reset release, reload from live values.

Source files
------------

// File: rtl/prog_field_editor.sv
// prog_field_editor: snapshots an RTC group on mode entry, edits three wrapped fields, strobes a commit on exit
module prog_field_editor #(
   parameter int FW = 7,
   parameter int YEAR_MAX = 99,
   parameter int DAY_MAX = 31
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    prog,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_right,
   input  logic          btn_left,
   input  logic [FW-1:0] live_f0,
   input  logic [FW-1:0] live_f1,
   input  logic [FW-1:0] live_f2,
   output logic [1:0]    mode,
   output logic [1:0]    cursor,
   output logic [FW-1:0] f0,
   output logic [FW-1:0] f1,
   output logic [FW-1:0] f2,
   output logic          wr_stb,
   output logic [1:0]    wr_grp
);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, EDIT = 2'd2, COMMIT = 2'd3;
   logic [1:0] state, grp, cur_nxt;
   logic [FW-1:0] sel, lo, hi, nxt;
   always_comb begin
      grp = prog == 3'b001 ? 2'b01 : prog == 3'b010 ? 2'b10 : prog == 3'b100 ? 2'b11 : 2'b00;
      sel = cursor == 2'd0 ? f0 : cursor == 2'd1 ? f1 : f2;
      // date day and month start at 1; every other field starts at 0
      lo = (mode == 2'b01 && cursor != 2'd2) ? FW'(1) : '0;
      hi = mode == 2'b01 ? (cursor == 2'd0 ? FW'(DAY_MAX) : cursor == 2'd1 ? FW'(12) : FW'(YEAR_MAX))
                         : (cursor == 2'd0 ? FW'(23) : FW'(59));
      nxt = btn_up ? (sel >= hi ? lo : sel + FW'(1)) : (sel <= lo ? hi : sel - FW'(1));
      cur_nxt = btn_right ? (cursor == 2'd2 ? 2'd0 : cursor + 2'd1) : (cursor == 2'd0 ? 2'd2 : cursor - 2'd1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mode <= 2'b00;
         cursor <= 2'd0;
         f0 <= '0;
         f1 <= '0;
         f2 <= '0;
         wr_stb <= 1'b0;
         wr_grp <= 2'b00;
      end else begin
         case (state)
            IDLE: if (grp != 2'b00) begin
               mode <= grp;
               state <= LOAD;
            end
            LOAD: begin
               f0 <= live_f0;
               f1 <= live_f1;
               f2 <= live_f2;
               cursor <= 2'd0;
               state <= EDIT;
            end
            EDIT: if (grp != mode) begin
               state <= COMMIT;
               wr_stb <= 1'b1;
               wr_grp <= mode;
            end else if (btn_up || btn_down) begin
               if (cursor == 2'd0) f0 <= nxt;
               else if (cursor == 2'd1) f1 <= nxt;
               else f2 <= nxt;
            end else if (btn_right || btn_left) begin
               cursor <= cur_nxt;
            end
            default: begin
               wr_stb <= 1'b0;
               wr_grp <= 2'b00;
               mode <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
